dmem_arbiter: RTL and testbench

Shares the single-ported data memory between the pipeline's memory stage (CPU port) and one auxiliary master (AUX port, e.g. I/O or display reader). The CPU has fixed priority; the AUX port is served on cycles the memory stage does not touch dmem. An optional starvation guard forces a grant to AUX and stalls the pipeline for one cycle. Sits between stage_memory's dmem outputs and the dmem macro.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_wait_ctr.sv | 37 +++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and defaults for the dmem arbiter.
//   - owner_t     : who drove dmem on the previous cycle
//   - DMEM_ADDR_W : default dmem word-address width
//   - DMEM_DATA_W : default dmem data width
//   - WAIT_W      : width of the AUX starvation wait counter
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;
    localparam int WAIT_W      = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// dmem_arb_wait_ctr
//   Counts the cycles the AUX master has been kept waiting and raises
//   force_gnt once it has waited MAX_WAIT cycles.
//   Used only in DMEM_ARB_STARVE_GUARD_EN builds.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   aux_req      : AUX request pending
//   aux_gnt      : AUX granted this cycle
//   force_gnt    : AUX must be granted this cycle regardless of the CPU
module dmem_arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic aux_req,
    input  logic aux_gnt,
    output logic force_gnt
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (aux_gnt || !aux_req)
            wait_cnt <= '0;
        else if (wait_cnt != MAX_CNT)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    assign force_gnt = aux_req && (wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported dmem between the memory stage (CPU, fixed
//   priority) and one auxiliary master (AUX). AUX is served on cycles the
//   CPU leaves dmem idle.
//   Optional macro DMEM_ARB_STARVE_GUARD_EN: after AUX has waited MAX_WAIT
//   cycles it is granted anyway and the pipeline is stalled for that cycle.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   cpu_req/wren/addr/d   : memory-stage access (lw/sw)
//   cpu_q, cpu_stall      : read data to writeback, pipeline freeze
//   aux_req/wren/addr/d   : AUX access, held until aux_gnt
//   aux_gnt, aux_rvalid   : AUX issued this cycle, AUX read data valid
//   aux_q                 : AUX read data
//   dmem_address/d/wren/q : dmem macro interface (q is one cycle late)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_d,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_wren,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_d,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_q,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_d,
    output logic              dmem_wren,
    input  logic [DATA_W-1:0] dmem_q
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..255");
    end

    logic   force_gnt;
    owner_t owner;
    logic   last_wren;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clock     (clock),
        .reset     (reset),
        .aux_req   (aux_req),
        .aux_gnt   (aux_gnt),
        .force_gnt (force_gnt)
    );
    assign cpu_stall = cpu_req && aux_gnt;
`else
    assign force_gnt = 1'b0;
    assign cpu_stall = 1'b0;
`endif

    // Gating with reset keeps dmem and both masters quiet while reset is held.
    assign aux_gnt = !reset && aux_req && (!cpu_req || force_gnt);

    always_comb begin
        if (aux_gnt) begin
            dmem_address = aux_addr;
            dmem_d       = aux_d;
            dmem_wren    = aux_wren;
        end else begin
            dmem_address = cpu_addr;
            dmem_d       = cpu_d;
            dmem_wren    = !reset && cpu_req && cpu_wren;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner     <= OWN_NONE;
            last_wren <= 1'b0;
        end else begin
            owner     <= aux_gnt ? OWN_AUX : (cpu_req ? OWN_CPU : OWN_NONE);
            last_wren <= dmem_wren;
        end
    end

    // dmem_q this cycle belongs to last cycle's issuer; only AUX reads flag it.
    assign aux_rvalid = (owner == OWN_AUX) && !last_wren;
    assign cpu_q      = dmem_q;
    assign aux_q      = dmem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_wren = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_d = '0;
    logic [DATA_W-1:0] cpu_q;
    logic              cpu_stall;
    logic              aux_req = 1'b0, aux_wren = 1'b0;
    logic [ADDR_W-1:0] aux_addr = '0;
    logic [DATA_W-1:0] aux_d = '0;
    logic              aux_gnt, aux_rvalid;
    logic [DATA_W-1:0] aux_q;
    logic [ADDR_W-1:0] dmem_address;
    logic [DATA_W-1:0] dmem_d;
    logic              dmem_wren;
    logic [DATA_W-1:0] dmem_q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_wren(aux_wren), .aux_addr(aux_addr), .aux_d(aux_d),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_q(aux_q),
        .dmem_address(dmem_address), .dmem_d(dmem_d), .dmem_wren(dmem_wren),
        .dmem_q(dmem_q)
    );

    // dmem macro model with a backdoor preload port
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;
    always @(posedge clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (dmem_wren) mem[dmem_address] <= dmem_d;
        dmem_q <= mem[dmem_address];
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [int];
    int                waited = 0;
    bit                pend_aux = 0, pend_cpu = 0, pend_known = 0;
    logic [DATA_W-1:0] pend_dat = '0;
    bit                e_gnt = 0, e_stall = 0, e_wren = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_d = '0;

    task automatic ref_eval();
        bit frc;
        frc = GUARD && aux_req && (waited >= MAX_WAIT);
        if (reset) begin
            e_gnt = 0; e_stall = 0; e_wren = 0;
            e_addr = cpu_addr; e_d = cpu_d;
        end else begin
            e_gnt   = aux_req && (!cpu_req || frc);
            e_stall = cpu_req && e_gnt;
            e_addr  = e_gnt ? aux_addr : cpu_addr;
            e_d     = e_gnt ? aux_d : cpu_d;
            e_wren  = e_gnt ? aux_wren : (cpu_req && cpu_wren);
        end
    endtask

    task automatic ref_advance();
        if (reset) begin
            waited = 0; pend_aux = 0; pend_cpu = 0; pend_known = 0;
        end else begin
            pend_aux   = e_gnt && !aux_wren;
            pend_cpu   = !e_gnt && cpu_req && !cpu_wren;
            pend_known = ref_mem.exists(int'(e_addr));
            pend_dat   = pend_known ? ref_mem[int'(e_addr)] : '0;
            if (e_wren) ref_mem[int'(e_addr)] = e_d;
            if (e_gnt || !aux_req) waited = 0;
            else if (waited < MAX_WAIT) waited = waited + 1;
        end
    endtask

    // inputs are driven 1 time unit after the edge; outputs sampled 3 later
    task automatic settle();
        #3;
        ref_eval();
    endtask

    task automatic tick();
        @(posedge clock);
        ref_advance();
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_wren = 0; aux_req = 0; aux_wren = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h005;
        aux_req = 1; aux_wren = 1; aux_addr = 12'h006;
        @(posedge clock); #1;
        settle();
        n_cmp++; if (dmem_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %b want 0", dmem_wren); end
        n_cmp++; if (aux_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0", aux_gnt); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        n_cmp++; if (aux_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", aux_rvalid); end
        tick();
        reset = 0; idle();
        settle();
        n_cmp++; if (aux_rvalid !== 1'b0) begin n_bad++; $display("FAIL post_reset_rvalid: got %b want 0", aux_rvalid); end
        n_cmp++; if (dmem_wren !== 1'b0) begin n_bad++; $display("FAIL post_reset_wren: got %b want 0", dmem_wren); end
        tick();
    endtask

    task automatic test_aux_rw();
        idle();
        aux_req = 1; aux_wren = 1; aux_addr = 12'h010; aux_d = 32'h1234_5678;
        settle();
        n_cmp++; if (aux_gnt !== 1'b1) begin n_bad++; $display("FAIL auxw_gnt: got %b want 1", aux_gnt); end
        n_cmp++; if (dmem_wren !== 1'b1 || dmem_address !== 12'h010 || dmem_d !== 32'h1234_5678) begin
            n_bad++; $display("FAIL auxw_bus: got wren=%b addr=%h d=%h want 1/010/12345678", dmem_wren, dmem_address, dmem_d); end
        tick();
        aux_wren = 0;
        settle();
        n_cmp++; if (aux_gnt !== 1'b1) begin n_bad++; $display("FAIL auxr_gnt: got %b want 1", aux_gnt); end
        n_cmp++; if (dmem_wren !== 1'b0) begin n_bad++; $display("FAIL auxr_wren: got %b want 0", dmem_wren); end
        n_cmp++; if (aux_rvalid !== 1'b0) begin n_bad++; $display("FAIL auxw_no_rvalid: got %b want 0", aux_rvalid); end
        tick();
        idle();
        settle();
        n_cmp++; if (aux_rvalid !== 1'b1) begin n_bad++; $display("FAIL auxr_rvalid: got %b want 1", aux_rvalid); end
        n_cmp++; if (aux_q !== 32'h1234_5678) begin n_bad++; $display("FAIL auxr_q: got %h want 12345678", aux_q); end
        tick();
        settle();
        n_cmp++; if (aux_rvalid !== 1'b0) begin n_bad++; $display("FAIL auxr_rvalid_drop: got %b want 0", aux_rvalid); end
        tick();
    endtask

    task automatic test_cpu_priority();
        cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h020; cpu_d = 32'hDEAD_BEEF;
        aux_req = 1; aux_wren = 0; aux_addr = 12'h030;
        settle();
        n_cmp++; if (aux_gnt !== 1'b0) begin n_bad++; $display("FAIL prio_gnt: got %b want 0", aux_gnt); end
        n_cmp++; if (dmem_wren !== 1'b1 || dmem_address !== 12'h020 || dmem_d !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL prio_bus: got wren=%b addr=%h d=%h want 1/020/deadbeef", dmem_wren, dmem_address, dmem_d); end
        tick();
        cpu_req = 0; cpu_wren = 0;
        settle();
        n_cmp++; if (aux_gnt !== 1'b1 || dmem_address !== 12'h030) begin
            n_bad++; $display("FAIL prio_aux_after: got gnt=%b addr=%h want 1/030", aux_gnt, dmem_address); end
        tick();
        aux_req = 0;
        cpu_req = 1; cpu_wren = 0; cpu_addr = 12'h020;
        settle();
        n_cmp++; if (aux_rvalid !== 1'b1) begin n_bad++; $display("FAIL prio_aux_rvalid: got %b want 1", aux_rvalid); end
        tick();
        idle();
        settle();
        n_cmp++; if (cpu_q !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL prio_cpu_sw: got %h want deadbeef", cpu_q); end
        tick();
    endtask

    task automatic test_cpu_lw();
        idle();
        bd_we = 1; bd_addr = 12'h040; bd_data = 32'd7;
        settle();
        tick();
        bd_we = 0;
        ref_mem[int'(12'h040)] = 32'd7;
        cpu_req = 1; cpu_wren = 0; cpu_addr = 12'h040;
        settle();
        tick();
        idle();
        settle();
        n_cmp++; if (cpu_q !== 32'd7) begin n_bad++; $display("FAIL lw_q: got %h want 7", cpu_q); end
        n_cmp++; if (aux_rvalid !== 1'b0) begin n_bad++; $display("FAIL lw_rvalid: got %b want 0", aux_rvalid); end
        tick();
    endtask

    task automatic test_starve();
        int ncyc;
        bit want;
        ncyc = GUARD ? 3 * (MAX_WAIT + 1) : 100;
        cpu_req = 1; cpu_wren = 0; cpu_addr = 12'h100;
        aux_req = 1; aux_wren = 0; aux_addr = 12'h200;
        for (int c = 1; c <= ncyc; c++) begin
            settle();
            want = GUARD && ((c % (MAX_WAIT + 1)) == 0);
            n_cmp++; if (aux_gnt !== want) begin n_bad++; $display("FAIL starve_gnt c=%0d: got %b want %b", c, aux_gnt, want); end
            n_cmp++; if (cpu_stall !== want) begin n_bad++; $display("FAIL starve_stall c=%0d: got %b want %b", c, cpu_stall, want); end
            n_cmp++; if (dmem_address !== (want ? 12'h200 : 12'h100)) begin
                n_bad++; $display("FAIL starve_addr c=%0d: got %h want %h", c, dmem_address, want ? 12'h200 : 12'h100); end
            tick();
        end
        idle();
        settle();
        tick();
    endtask

    task automatic test_reset_mid_read();
        idle();
        aux_req = 1; aux_wren = 0; aux_addr = 12'h010;
        settle();
        n_cmp++; if (aux_gnt !== 1'b1) begin n_bad++; $display("FAIL rmr_gnt: got %b want 1", aux_gnt); end
        tick();
        reset = 1;
        aux_wren = 1; cpu_req = 1; cpu_wren = 1;
        settle();
        n_cmp++; if (aux_rvalid !== 1'b0) begin n_bad++; $display("FAIL rmr_rvalid: got %b want 0", aux_rvalid); end
        n_cmp++; if (dmem_wren !== 1'b0 || aux_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            n_bad++; $display("FAIL rmr_quiet: got wren=%b gnt=%b stall=%b want 0/0/0", dmem_wren, aux_gnt, cpu_stall); end
`ifdef DMEM_ARB_STARVE_GUARD_EN
        n_cmp++; if (u_dut.u_wait.wait_cnt !== 8'd0) begin n_bad++; $display("FAIL rmr_wait_cnt: got %0d want 0", u_dut.u_wait.wait_cnt); end
`endif
        tick();
        reset = 0; idle();
        settle();
        n_cmp++; if (aux_rvalid !== 1'b0) begin n_bad++; $display("FAIL rmr_after: got %b want 0", aux_rvalid); end
        tick();
    endtask

    task automatic test_random();
        bit first;
        first = 1;
        for (int i = 0; i < 400; i++) begin
            // a stalled CPU access is reissued unchanged; AUX holds until granted
            if (first || !e_stall) begin
                cpu_req  = ($urandom_range(0, 99) < 70);
                cpu_wren = 1'($urandom_range(0, 1));
                cpu_addr = ADDR_W'($urandom_range(0, 15));
                cpu_d    = $urandom;
            end
            if (first || !aux_req || e_gnt) begin
                aux_req  = 1'($urandom_range(0, 1));
                aux_wren = 1'($urandom_range(0, 1));
                aux_addr = ADDR_W'($urandom_range(0, 15));
                aux_d    = $urandom;
            end
            first = 0;
            settle();
            n_cmp++; if (aux_gnt !== e_gnt) begin n_bad++; $display("FAIL rnd_gnt i=%0d: got %b want %b", i, aux_gnt, e_gnt); end
            n_cmp++; if (cpu_stall !== e_stall) begin n_bad++; $display("FAIL rnd_stall i=%0d: got %b want %b", i, cpu_stall, e_stall); end
            n_cmp++; if (dmem_wren !== e_wren) begin n_bad++; $display("FAIL rnd_wren i=%0d: got %b want %b", i, dmem_wren, e_wren); end
            n_cmp++; if (dmem_address !== e_addr) begin n_bad++; $display("FAIL rnd_addr i=%0d: got %h want %h", i, dmem_address, e_addr); end
            if (e_wren) begin
                n_cmp++; if (dmem_d !== e_d) begin n_bad++; $display("FAIL rnd_d i=%0d: got %h want %h", i, dmem_d, e_d); end
            end
            n_cmp++; if (aux_rvalid !== pend_aux) begin n_bad++; $display("FAIL rnd_rvalid i=%0d: got %b want %b", i, aux_rvalid, pend_aux); end
            if (pend_aux && pend_known) begin
                n_cmp++; if (aux_q !== pend_dat) begin n_bad++; $display("FAIL rnd_aux_q i=%0d: got %h want %h", i, aux_q, pend_dat); end
            end
            if (pend_cpu && pend_known) begin
                n_cmp++; if (cpu_q !== pend_dat) begin n_bad++; $display("FAIL rnd_cpu_q i=%0d: got %h want %h", i, cpu_q, pend_dat); end
            end
            tick();
        end
        idle();
        settle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aux_rw();
        test_cpu_priority();
        test_cpu_lw();
        test_starve();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
